cla_word_sequencer: RTL and testbench



---
 rtl/cla_word_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_cla_word_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/cla_word_sequencer.sv
// cla_word_sequencer: W = 32*NWORDS bit add built by feeding one 32-bit carry-lookahead
// adder one word per cycle, LSW first. Define CLA_SEQ_SUB_EN to add the `sub` port and subtract.

module cla (
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        ci,
  output logic [31:0] sum,
  output logic        co
);
  logic [31:0] g;
  logic [31:0] p;
  logic [7:0]  gg;
  logic [7:0]  gp;
  logic [8:0]  gc;
  logic [31:0] c;

  // Two-level lookahead: 4-bit groups, then a lookahead chain across the 8 group carries.
  always_comb begin
    g  = x & y;
    p  = x ^ y;
    gg = '0;
    gp = '0;
    gc = '0;
    c  = '0;
    for (int j = 0; j < 8; j++) begin
      gg[j] = g[4*j+3]
            | (p[4*j+3] & g[4*j+2])
            | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      gp[j] = &p[4*j +: 4];
    end
    gc[0] = ci;
    for (int j = 0; j < 8; j++) begin
      gc[j+1] = gg[j] | (gp[j] & gc[j]);
    end
    for (int j = 0; j < 8; j++) begin
      c[4*j]   = gc[j];
      c[4*j+1] = g[4*j]   | (p[4*j]   & gc[j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j])   | (p[4*j+1] & p[4*j] & gc[j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
    end
    sum = p ^ c;
    co  = gc[8];
  end
endmodule

module cla_word_sequencer #(
  parameter  int NWORDS = 4,
  localparam int W      = 32 * NWORDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
`ifdef CLA_SEQ_SUB_EN
  input  logic         sub,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] s,
  output logic         c_out
);
  localparam int            KW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NWORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q;
  state_t        state_d;
  logic [KW-1:0] k_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic          cr_q;
  logic [W-1:0]  s_q;
  logic          c_out_q;
  logic [31:0]   a_word;
  logic [31:0]   b_word;
  logic [31:0]   sum_word;
  logic          carry_word;
  logic          cr_load;
  logic          accept;
  logic          step;
  logic          last;

`ifdef CLA_SEQ_SUB_EN
  logic sub_q;
  // Subtract is A + ~B + ~borrow_in, so the carry register starts inverted.
  assign cr_load = c_in ^ sub;
`else
  assign cr_load = c_in;
`endif

  always_comb begin
    a_word = '0;
    b_word = '0;
    for (int i = 0; i < NWORDS; i++) begin
      if (k_q == KW'(i)) begin
        a_word = a_q[32*i +: 32];
        b_word = b_q[32*i +: 32];
      end
    end
`ifdef CLA_SEQ_SUB_EN
    b_word = b_word ^ {32{sub_q}};
`endif
  end

  cla u_cla (
    .x   (a_word),
    .y   (b_word),
    .ci  (cr_q),
    .sum (sum_word),
    .co  (carry_word)
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    last    = (k_q == K_LAST);
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      cr_q    <= 1'b0;
      s_q     <= '0;
      c_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        k_q  <= '0;
        cr_q <= cr_load;
      end else if (step) begin
        cr_q <= carry_word;
        for (int i = 0; i < NWORDS; i++) begin
          if (k_q == KW'(i)) s_q[32*i +: 32] <= sum_word;
        end
        if (last) c_out_q <= carry_word;
        else      k_q     <= k_q + 1'b1;
      end
    end
  end

  // Operand registers only change on accept, so they need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= a;
      b_q <= b;
`ifdef CLA_SEQ_SUB_EN
      sub_q <= sub;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign s         = s_q;
  assign c_out     = c_out_q;
endmodule

// File: tb/tb_cla_word_sequencer.sv
// Bench for cla_word_sequencer: vector table, handshake corner cases and random ops vs a wide-arithmetic model.
module tb_cla_word_sequencer;
  localparam int NW = 4;
  localparam int W  = 32 * NW;
`ifdef CLA_SEQ_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, in_ready, c_in, sub, out_valid, out_ready, c_out;
  logic [W-1:0] a, b, s;
  logic         in_valid1, in_ready1, c_in1, sub1, out_valid1, out_ready1, c_out1;
  logic [31:0]  a1, b1, s1;

  int total = 0;
  int bad   = 0;

  cla_word_sequencer #(.NWORDS(NW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in),
`ifdef CLA_SEQ_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .s(s), .c_out(c_out)
  );

  cla_word_sequencer #(.NWORDS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .c_in(c_in1),
`ifdef CLA_SEQ_SUB_EN
    .sub(sub1),
`endif
    .out_valid(out_valid1), .out_ready(out_ready1), .s(s1), .c_out(c_out1)
  );

  typedef struct {
    logic [127:0] va;
    logic [127:0] vb;
    logic         vci;
    logic         vsub;
    logic [127:0] exp_s;
    logic         exp_c;
  } vec_t;

  task automatic check(input string name, input logic [128:0] got, input logic [128:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: plain wide arithmetic on the whole operands.
  function automatic logic [128:0] model(input logic [127:0] x, input logic [127:0] y,
                                         input logic ci, input logic sb);
    logic [128:0] r;
    if (sb) begin
      r[127:0] = x - y - 128'(ci);
      r[128]   = ({1'b0, x} >= ({1'b0, y} + 129'(ci)));
    end else begin
      r = {1'b0, x} + {1'b0, y} + 129'(ci);
    end
    return r;
  endfunction

  // Called #1 after a rising edge with the DUT idle; returns {c_out, s} and cycles to out_valid.
  task automatic do_op(input logic [127:0] ta, input logic [127:0] tb_v, input logic ci,
                       input logic sb, output logic [128:0] res, output int lat);
    check("idle_in_ready", 129'(in_ready), 129'(1));
    a = ta; b = tb_v; c_in = ci; sub = sb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = {4{$urandom}}; b = {4{$urandom}}; c_in = 1'($urandom); sub = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    res = {c_out, s};
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_done_in_ready", 129'(in_ready), 129'(1));
    check("post_done_out_valid", 129'(out_valid), 129'(0));
  endtask

  vec_t         vecs[$];
  logic [128:0] res;
  int           lat;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; c_in1 = 1'b0; sub1 = 1'b0;

    vecs.push_back('{ {128{1'b1}}, 128'd1, 1'b0, 1'b0, 128'd0, 1'b1 });
    vecs.push_back('{ 128'h0000_0000_FFFF_FFFF, 128'd1, 1'b0, 1'b0, 128'h1_0000_0000, 1'b0 });
    vecs.push_back('{ 128'd3, 128'd4, 1'b0, 1'b0, 128'd7, 1'b0 });
    vecs.push_back('{ {128{1'b1}}, 128'd0, 1'b1, 1'b0, 128'd0, 1'b1 });
    vecs.push_back('{ {1'b1, 127'd0}, {1'b1, 127'd0}, 1'b0, 1'b0, 128'd0, 1'b1 });
    vecs.push_back('{ 128'h0000_0001_FFFF_FFFF_FFFF_FFFF_0000_0000,
                      128'h0000_0000_0000_0000_0000_0001_0000_0000, 1'b0, 1'b0,
                      128'h0000_0002_0000_0000_0000_0000_0000_0000, 1'b0 });
`ifdef CLA_SEQ_SUB_EN
    vecs.push_back('{ 128'd5, 128'd7, 1'b0, 1'b1, {{127{1'b1}}, 1'b0}, 1'b0 });
    vecs.push_back('{ 128'd7, 128'd5, 1'b0, 1'b1, 128'd2, 1'b1 });
    vecs.push_back('{ 128'd7, 128'd5, 1'b1, 1'b1, 128'd1, 1'b1 });
    vecs.push_back('{ 128'd3, 128'd4, 1'b0, 1'b0, 128'd7, 1'b0 });
`endif

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready", 129'(in_ready), 129'(1));
    check("rst_out_valid", 129'(out_valid), 129'(0));
    check("rst_s_cout", {c_out, s}, 129'(0));
    check("rst1_s_cout", {c_out1, s1}, 129'(0));

    foreach (vecs[i]) begin
      do_op(vecs[i].va, vecs[i].vb, vecs[i].vci, vecs[i].vsub, res, lat);
      check($sformatf("vec%0d_latency", i), 129'(lat), 129'(NW));
      check($sformatf("vec%0d_result", i), res, {vecs[i].exp_c, vecs[i].exp_s});
      release_result();
    end

    // Backpressure: result must hold and pulsed requests must be refused.
    do_op(128'd0, 128'd0, 1'b1, 1'b0, res, lat);
    check("bp_result", res, 129'(1));
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0] ? 1'b0 : 1'b1;
      a = 128'd100; b = 128'd200; c_in = 1'b0;
      @(posedge clk); #1;
      check("bp_hold_result", {c_out, s}, 129'(1));
      check("bp_out_valid", 129'(out_valid), 129'(1));
      check("bp_in_ready", 129'(in_ready), 129'(0));
    end
    in_valid = 1'b0;
    release_result();
    repeat (6) @(posedge clk);
    #1 check("bp_no_accept", 129'(out_valid), 129'(0));

    // Reset during the second RUN cycle abandons the operation.
    a = {128{1'b1}}; b = 128'd1; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrun_rst_in_ready", 129'(in_ready), 129'(1));
    check("midrun_rst_out_valid", 129'(out_valid), 129'(0));
    check("midrun_rst_s_cout", {c_out, s}, 129'(0));
    do_op(128'd3, 128'd4, 1'b0, 1'b0, res, lat);
    check("after_rst_result", res, 129'(7));
    release_result();

    // Random operations against the model.
    for (int i = 0; i < 24; i++) begin
      logic [127:0] ra, rb;
      logic         rci, rsb;
      ra  = {$urandom, $urandom, $urandom, $urandom};
      rb  = {$urandom, $urandom, $urandom, $urandom};
      if (i % 6 == 1) ra = {128{1'b1}};
      if (i % 6 == 2) rb = ~ra;
      rci = 1'($urandom);
      rsb = SUB_EN ? 1'($urandom) : 1'b0;
      do_op(ra, rb, rci, rsb, res, lat);
      check("rand_latency", 129'(lat), 129'(NW));
      check("rand_result", res, model(ra, rb, rci, rsb));
      release_result();
    end

    // Single-word configuration.
    for (int i = 0; i < 6; i++) begin
      logic [31:0] xa, xb;
      logic        xci;
      logic [128:0] exp1;
      xa = (i == 0) ? 32'hFFFF_FFFF : $urandom;
      xb = (i == 0) ? 32'hFFFF_FFFF : $urandom;
      xci = (i == 0) ? 1'b1 : 1'($urandom);
      exp1 = model(128'(xa), 128'(xb), xci, 1'b0);
      check("w1_in_ready", 129'(in_ready1), 129'(1));
      a1 = xa; b1 = xb; c_in1 = xci; sub1 = 1'b0; in_valid1 = 1'b1;
      @(posedge clk); #1;
      in_valid1 = 1'b0; a1 = $urandom; b1 = $urandom;
      lat = 0;
      while (!out_valid1 && lat < 50) begin
        @(posedge clk); #1;
        lat++;
      end
      check("w1_latency", 129'(lat), 129'(1));
      check("w1_result", {c_out1, s1}, {exp1[32], exp1[31:0]});
      out_ready1 = 1'b1;
      @(posedge clk); #1;
      out_ready1 = 1'b0;
      check("w1_post_in_ready", 129'(in_ready1), 129'(1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
